// File: rtl/spi_req_arbiter.sv
// Two-requester round-robin front end for an SPI master.
// Grants one requester, forwards its byte and mode, tracks SS_b and returns rx data.
module spi_req_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [7:0] tx0_data,
   input  logic [7:0] tx1_data,
   input  logic [2:0] mode0,
   input  logic [2:0] mode1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       err,
   output logic [7:0] rx_data,
   output logic       busy,
   output logic       SPI_RDY,
   output logic [7:0] Data_in,
   output logic       LSBFE,
   output logic       cpol,
   output logic       cpha,
   input  logic       SS_b,
   input  logic [7:0] Data_out
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] SETUP     = 3'd1;
   localparam logic [2:0] START     = 3'd2;
   localparam logic [2:0] WAIT_LOW  = 3'd3;
   localparam logic [2:0] WAIT_HIGH = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [2:0] state;
   logic [7:0] cnt;
   logic       last;
   logic       ss_seen;
   logic [1:0] win;

   // last=1 means requester 1 won most recently, so requester 0 wins a tie
   always_comb begin
      win    = 2'b00;
      win[0] = req[0] & (~req[1] | last);
      win[1] = req[1] & (~req[0] | ~last);
   end

   assign SPI_RDY = (state == START);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 8'd0;
         last    <= 1'b1;
         ss_seen <= 1'b0;
         gnt     <= 2'b00;
         done    <= 2'b00;
         err     <= 1'b0;
         rx_data <= 8'h00;
         Data_in <= 8'h00;
         LSBFE   <= 1'b0;
         cpol    <= 1'b0;
         cpha    <= 1'b0;
      end else begin
         done <= 2'b00;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= win;
                  state <= SETUP;
                  if (win[0]) begin
                     Data_in              <= tx0_data;
                     {LSBFE, cpol, cpha}  <= mode0;
                  end else begin
                     Data_in              <= tx1_data;
                     {LSBFE, cpol, cpha}  <= mode1;
                  end
               end
            end
            SETUP: begin
               state <= START;
            end
            START: begin
               // a slave that drops SS_b alongside the strobe must not be missed
               cnt     <= 8'd0;
               ss_seen <= ~SS_b;
               state   <= WAIT_LOW;
            end
            WAIT_LOW: begin
               if (!SS_b || ss_seen) begin
                  ss_seen <= 1'b0;
                  state   <= WAIT_HIGH;
               end else if (cnt == TO_LAST) begin
                  done  <= gnt;
                  err   <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WAIT_HIGH: begin
               if (SS_b) begin
                  done    <= gnt;
                  rx_data <= Data_out;
                  state   <= DONE;
               end
            end
            DONE: begin
               last  <= gnt[1];
               gnt   <= 2'b00;
               state <= IDLE;
            end
            default: begin
               gnt   <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter with a scoreboard of completed transfers.
module tb_spi_req_arbiter;

   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [7:0] tx0_data;
   logic [7:0] tx1_data;
   logic [2:0] mode0;
   logic [2:0] mode1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic       err;
   logic [7:0] rx_data;
   logic       busy;
   logic       SPI_RDY;
   logic [7:0] Data_in;
   logic       LSBFE;
   logic       cpol;
   logic       cpha;
   logic       SS_b;
   logic [7:0] Data_out;

   int vectors;
   int miscompares;

   typedef struct packed {
      logic [1:0] g;
      logic [7:0] rx;
      logic       e;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] rx_model;

   spi_req_arbiter #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .tx0_data (tx0_data),
      .tx1_data (tx1_data),
      .mode0    (mode0),
      .mode1    (mode1),
      .gnt      (gnt),
      .done     (done),
      .err      (err),
      .rx_data  (rx_data),
      .busy     (busy),
      .SPI_RDY  (SPI_RDY),
      .Data_in  (Data_in),
      .LSBFE    (LSBFE),
      .cpol     (cpol),
      .cpha     (cpha),
      .SS_b     (SS_b),
      .Data_out (Data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cfg(input logic [7:0] ed, input logic [2:0] em);
      chk("data_in", 32'(Data_in), 32'(ed));
      chk("mode", 32'({LSBFE, cpol, cpha}), 32'(em));
   endtask

   task automatic chk_reset();
      chk("rst_gnt", 32'(gnt), 32'(2'b00));
      chk("rst_done", 32'(done), 32'(2'b00));
      chk("rst_err", 32'(err), 32'(1'b0));
      chk("rst_busy", 32'(busy), 32'(1'b0));
      chk("rst_rdy", 32'(SPI_RDY), 32'(1'b0));
      chk("rst_data_in", 32'(Data_in), 32'(8'h00));
      chk("rst_mode", 32'({LSBFE, cpol, cpha}), 32'(3'b000));
      chk("rst_rx", 32'(rx_data), 32'(8'h00));
   endtask

   // req must already be driven during an IDLE cycle when this is called
   task automatic txn(input logic [1:0] eg, input logic [7:0] ed,
                      input logic [2:0] em, input logic [1:0] req_after,
                      input int low_dly, input int high_len,
                      input logic [7:0] dout, input bit tmo);
      int   n;
      exp_t e;
      e.g  = eg;
      e.e  = tmo;
      e.rx = tmo ? rx_model : dout;
      if (!tmo) rx_model = dout;
      sb.push_back(e);
      n = 0;
      do begin
         tick();
         n++;
      end while (gnt == 2'b00 && n < 8);
      chk("grant_latency", 32'(n), 32'(1));
      req = req_after;
      if (req_after == 2'b00) begin
         tx0_data = 8'h00;
         tx1_data = 8'h00;
         mode0    = 3'b010;
         mode1    = 3'b010;
      end
      chk("gnt", 32'(gnt), 32'(eg));
      chk("busy_setup", 32'(busy), 32'(1'b1));
      chk("rdy_setup", 32'(SPI_RDY), 32'(1'b0));
      chk_cfg(ed, em);
      tick();
      chk("rdy_pulse", 32'(SPI_RDY), 32'(1'b1));
      for (int i = 0; i < low_dly; i++) begin
         tick();
         chk("rdy_low", 32'(SPI_RDY), 32'(1'b0));
         chk_cfg(ed, em);
      end
      if (!tmo) begin
         SS_b = 1'b0;
         for (int i = 0; i < high_len; i++) begin
            tick();
            chk("no_early_done", 32'(done), 32'(2'b00));
            chk_cfg(ed, em);
         end
         Data_out = dout;
         SS_b     = 1'b1;
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (done == 2'b00 && n < TO + 4);
      chk("done_latency", 32'(n), tmo ? 32'(TO + 1 - low_dly) : 32'(1));
      e = sb.pop_front();
      chk("done", 32'(done), 32'(e.g));
      chk("err", 32'(err), 32'(e.e));
      chk("rx", 32'(rx_data), 32'(e.rx));
      chk("gnt_at_done", 32'(gnt), 32'(e.g));
      chk_cfg(ed, em);
      tick();
      chk("done_clr", 32'(done), 32'(2'b00));
      chk("err_clr", 32'(err), 32'(1'b0));
      chk("gnt_clr", 32'(gnt), 32'(2'b00));
      chk("busy_idle", 32'(busy), 32'(1'b0));
      chk("rx_hold", 32'(rx_data), 32'(e.rx));
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rx_model    = 8'h00;
      rst      = 1'b1;
      req      = 2'b00;
      tx0_data = 8'h00;
      tx1_data = 8'h00;
      mode0    = 3'b000;
      mode1    = 3'b000;
      SS_b     = 1'b1;
      Data_out = 8'h00;
      tick();
      tick();
      chk_reset();
      rst = 1'b0;
      tick();

      // single request
      req      = 2'b01;
      tx0_data = 8'hA5;
      mode0    = 3'b000;
      txn(2'b01, 8'hA5, 3'b000, 2'b00, 3, 16, 8'h3C, 1'b0);

      // mode forwarding, SS_b falls with the strobe
      req      = 2'b10;
      tx1_data = 8'h81;
      mode1    = 3'b111;
      txn(2'b10, 8'h81, 3'b111, 2'b00, 0, 5, 8'hC3, 1'b0);

      // timeout with SS_b stuck high
      req      = 2'b01;
      tx0_data = 8'h5A;
      mode0    = 3'b101;
      Data_out = 8'hEE;
      txn(2'b01, 8'h5A, 3'b101, 2'b00, 0, 0, 8'h00, 1'b1);

      // reset in WAIT_HIGH
      req      = 2'b10;
      tx1_data = 8'h33;
      mode1    = 3'b011;
      tick();
      chk("mid_gnt", 32'(gnt), 32'(2'b10));
      req = 2'b00;
      tick();
      chk("mid_rdy", 32'(SPI_RDY), 32'(1'b1));
      SS_b = 1'b0;
      tick();
      tick();
      chk("mid_busy", 32'(busy), 32'(1'b1));
      chk("mid_gnt_hold", 32'(gnt), 32'(2'b10));
      Data_out = 8'h77;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset();
      rx_model = 8'h00;
      SS_b     = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_done_after_rst", 32'(done), 32'(2'b00));
      end
      req      = 2'b01;
      tx0_data = 8'h11;
      mode0    = 3'b001;
      txn(2'b01, 8'h11, 3'b001, 2'b00, 2, 4, 8'h5D, 1'b0);

      // continuous contention from a fresh pointer
      rst = 1'b1;
      tick();
      chk_reset();
      rst      = 1'b0;
      rx_model = 8'h00;
      tick();
      req      = 2'b11;
      tx0_data = 8'h10;
      tx1_data = 8'h20;
      mode0    = 3'b001;
      mode1    = 3'b110;
      txn(2'b01, 8'h10, 3'b001, 2'b11, 1, 3, 8'hA1, 1'b0);
      txn(2'b10, 8'h20, 3'b110, 2'b11, 1, 3, 8'hA2, 1'b0);
      txn(2'b01, 8'h10, 3'b001, 2'b11, 1, 3, 8'hA3, 1'b0);
      txn(2'b10, 8'h20, 3'b110, 2'b00, 1, 3, 8'hA4, 1'b0);
      tick();
      chk("final_idle", 32'(busy), 32'(1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 64, cycles allowed for SS_b to fall after the SPI_RDY pulse before aborting; legal range 2..255.
REQ-002 clk  input  1  single system clock; all logic is on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  2  per-requester transfer request, level; bit i = requester i.
REQ-005 tx0_data / tx1_data  input  8  byte to transmit for requester 0 / 1.
REQ-006 mode0 / mode1  input  3  per-requester config {LSBFE,cpol,cpha}, bit 2 = LSBFE.
REQ-007 gnt  output  2  one-hot grant; high for the whole transaction of the owning requester.
REQ-008 done  output  2  one-cycle completion pulse to the owning requester.
REQ-009 err  output  1  valid with done; 1 = transaction aborted on timeout.
REQ-010 rx_data  output  8  received byte, valid from the done pulse until the next done.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 SPI_RDY  output  1  start strobe to the SPI master.
REQ-013 Data_in  output  8  transmit byte to the SPI master.
REQ-014 LSBFE, cpol, cpha  output  1 each  mode config to the SPI master.
REQ-015 SS_b  input  1  slave select from the SPI master, active-low; a low period marks a transfer in progress.
REQ-016 Data_out  input  8  received byte from the SPI master.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, START, WAIT_LOW, WAIT_HIGH, DONE.
REQ-018 req SHALL be sampled in IDLE only; changes to req in any other state are ignored.
REQ-019 IDLE: if req is nonzero, the controller SHALL pick a winner, latch its txN_data and modeN, assert the matching gnt bit and enter SETUP on the next edge.
REQ-020 Arbitration SHALL be round-robin on a 1-bit last-winner pointer; on a tie the requester that was not the last winner wins; after reset the pointer favours requester 0.
REQ-021 Data_in, LSBFE, cpol and cpha SHALL take the latched values at entry to SETUP and hold until the next grant; SETUP lasts exactly 1 cycle, which lets the master's mode-select path settle before the strobe.
REQ-022 START: SPI_RDY SHALL be 1 for exactly one cycle, then the FSM enters WAIT_LOW; SPI_RDY is 0 in all other states.
REQ-023 WAIT_LOW: the FSM SHALL go to WAIT_HIGH on the first cycle SS_b==0.
REQ-024 WAIT_LOW timeout: an 8-bit counter SHALL clear on entry and increment each cycle; when it reaches TIMEOUT-1 with SS_b still 1, the FSM enters DONE with err=1.
REQ-025 WAIT_HIGH: the FSM SHALL go to DONE on the first cycle SS_b==1; WAIT_HIGH has no timeout.
REQ-026 DONE lasts 1 cycle and SHALL do all of the following:
  - capture Data_out into rx_data (rx_data is left unchanged when err=1);
  - pulse done for the owner;
  - drive err;
  - clear gnt;
  - update the last-winner pointer;
  - return to IDLE.
REQ-027 Latency from the IDLE grant to the SPI_RDY pulse SHALL be 2 cycles; minimum turnaround from done to the next gnt SHALL be 1 cycle (IDLE).
REQ-028 If SS_b falls in the same cycle as SPI_RDY, it SHALL be seen in the first WAIT_LOW cycle and not be lost.
REQ-029 err SHALL be 0 whenever done is 0.

Reset
REQ-030 With rst=1 at a rising edge, the FSM SHALL return to IDLE from any state, including mid-transfer.
REQ-031 Reset values: gnt=0, done=0, err=0, busy=0, SPI_RDY=0, Data_in=0x00, LSBFE=0, cpol=0, cpha=0, rx_data=0x00, pointer favours requester 0, timeout counter=0.
REQ-032 A transaction interrupted by reset SHALL produce no done pulse.

Verification
REQ-033 Single request: req=01, tx0_data=0xA5, mode0=3'b000; slave model lowers SS_b 3 cycles after SPI_RDY, raises it 16 cycles later, Data_out=0x3C -> gnt=01, SPI_RDY pulse 2 cycles after grant, done=01, rx_data=0x3C, err=0.
REQ-034 Simultaneous requests: req=11 held continuously -> grants alternate 01,10,01,10, each with a 1-cycle IDLE gap.
REQ-035 Mode forwarding: req=10, mode1=3'b111, tx1_data=0x81 -> LSBFE=cpol=cpha=1 and Data_in=0x81 stable from SETUP through DONE.
REQ-036 Timeout: SS_b held 1, TIMEOUT=8 -> done pulse with err=1 exactly 8 WAIT_LOW cycles after the START cycle; rx_data unchanged.
REQ-037 Reset mid-operation: rst asserted in WAIT_HIGH -> next cycle gnt=0, busy=0, SPI_RDY=0, no done; the next req=01 is granted to requester 0.
